// File: rtl/cordic_pkg.sv
// Shared constants for the multimode CORDIC engine.
// Holds the arctangent table, the inverse CORDIC gain, the pi constants,
// the mode encodings and the FSM state encoding. Every constant is stored
// at high precision and rescaled to the engine's fractional width by the
// engine itself.
package cordic_pkg;

    // atan(2^-i) in Q2.30, i = 0..31
    localparam logic [31:0] ATAN_Q30 [32] = '{
        32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
        32'd67021687,  32'd33543516,  32'd16775851,  32'd8388437,
        32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
        32'd262144,    32'd131072,    32'd65536,     32'd32768,
        32'd16384,     32'd8192,      32'd4096,      32'd2048,
        32'd1024,      32'd512,       32'd256,       32'd128,
        32'd64,        32'd32,        32'd16,        32'd8,
        32'd4,         32'd2,         32'd1,         32'd1
    };

    // 1/K = 0.6072529350 in Q2.30
    localparam logic [31:0] KINV_Q30    = 32'd652032874;
    // pi and pi/2 in Q3.29
    localparam logic [31:0] PI_Q29      = 32'd1686629713;
    localparam logic [31:0] HALF_PI_Q29 = 32'd843314857;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ITER  = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } cordic_state_t;

endpackage

// File: rtl/cordic_sat.sv
// Signed saturator: narrows an IW-bit two's complement value to OW bits.
// Ports:
//   din  - wide signed input
//   dout - narrowed value, clipped to [-2^(OW-1), 2^(OW-1)-1]
//   clip - high when din did not fit and dout was clipped
module cordic_sat
    import cordic_pkg::*;
#(
    parameter int IW = 18,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 clip
);

    localparam logic signed [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

    always_comb begin
        // The value fits when every bit above the output sign bit equals the sign.
        clip = (din[IW-1:OW-1] != {(IW-OW+1){din[IW-1]}});
        if (clip) begin
            dout = din[IW-1] ? MIN_V : MAX_V;
        end else begin
            dout = din[OW-1:0];
        end
    end

endmodule

// File: rtl/cordic_multimode.sv
// Iterative CORDIC engine: rotation mode rotates (x,y) by z, vectoring mode
// returns magnitude and atan2(y,x). A quadrant pre-rotation extends coverage
// to the full [-pi, pi) range; optional 1/K gain compensation; saturating
// outputs. One operation in flight, valid/ready on both sides.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid/in_ready       - operand handshake (ready only while idle)
//   in_mode                 - 0 rotation, 1 vectoring
//   in_x/in_y/in_z          - signed fixed-point operands, FL fractional bits
//   out_valid/out_ready     - result handshake, result held until accepted
//   out_x/out_y/out_z       - results (x', y', residual z / magnitude, ~0, angle)
//   out_sat                 - at least one result was clipped
module cordic_multimode
    import cordic_pkg::*;
#(
    parameter int WL        = 16,
    parameter int FL        = 13,
    parameter int N_ITER    = 15,
    parameter int GUARD     = 2,
    parameter int COMP_GAIN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic signed [WL-1:0] in_x,
    input  logic signed [WL-1:0] in_y,
    input  logic signed [WL-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] out_x,
    output logic signed [WL-1:0] out_y,
    output logic signed [WL-1:0] out_z,
    output logic                 out_sat
);

    localparam int IW = WL + GUARD;
    localparam int PW = 2 * IW;
    localparam int CW = 5;

    // Rescale a high-precision constant by sh bits, rounding half-up.
    function automatic logic signed [IW-1:0] round_const(input logic [31:0] q, input int sh);
        logic [32:0] t;
        t = {1'b0, q} + (33'd1 << (sh - 1));
        t = t >> sh;
        return $signed(t[IW-1:0]);
    endfunction

    // Drop FL fractional bits of a gain product, rounding half-up.
    function automatic logic signed [IW-1:0] round_prod(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] half;
        logic signed [PW-1:0] t;
        half        = '0;
        half[FL-1]  = 1'b1;
        t           = (p + half) >>> FL;
        return $signed(t[IW-1:0]);
    endfunction

    function automatic logic signed [IW-1:0] sext(input logic signed [WL-1:0] v);
        return {{GUARD{v[WL-1]}}, v};
    endfunction

    localparam logic signed [IW-1:0] HALF_PI_FL = round_const(HALF_PI_Q29, 29 - FL);
    localparam logic signed [IW-1:0] KINV_FL    = round_const(KINV_Q30, 30 - FL);

    cordic_state_t        state;
    logic                 mode;
    logic [CW-1:0]        cnt;
    logic signed [IW-1:0] x_r, y_r, z_r;
    logic signed [IW-1:0] x_nx, y_nx, z_nx;
    logic signed [IW-1:0] xs, ys, atan_i;
    logic signed [PW-1:0] px, py;
    logic signed [WL-1:0] sx, sy, sz;
    logic                 cx, cy, cz;
    logic                 capture, last_iter, load_out, d_pos;

    assign capture   = (state == ST_IDLE) && in_valid && in_ready;
    assign last_iter = (state == ST_ITER) && (cnt == CW'(N_ITER - 1));
    // Results are registered on the edge that produces the final x/y/z,
    // so the saturators see next-state values rather than the accumulators.
    assign load_out  = (COMP_GAIN != 0) ? (state == ST_SCALE) : last_iter;
    assign atan_i    = round_const(ATAN_Q30[cnt], 30 - FL);
    assign px        = PW'(x_r) * PW'(KINV_FL);
    assign py        = PW'(y_r) * PW'(KINV_FL);

    always_comb begin
        x_nx  = x_r;
        y_nx  = y_r;
        z_nx  = z_r;
        d_pos = 1'b0;
        xs    = x_r >>> cnt;
        ys    = y_r >>> cnt;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    x_nx = sext(in_x);
                    y_nx = sext(in_y);
                    z_nx = (in_mode == MODE_VEC) ? '0 : sext(in_z);
                end
            end
            ST_PRE: begin
                if (mode == MODE_ROT) begin
                    if (z_r > HALF_PI_FL) begin
                        x_nx = -y_r;
                        y_nx = x_r;
                        z_nx = z_r - HALF_PI_FL;
                    end else if (z_r < -HALF_PI_FL) begin
                        x_nx = y_r;
                        y_nx = -x_r;
                        z_nx = z_r + HALF_PI_FL;
                    end
                end else if (x_r[IW-1]) begin
                    if (!y_r[IW-1]) begin
                        x_nx = y_r;
                        y_nx = -x_r;
                        z_nx = HALF_PI_FL;
                    end else begin
                        x_nx = -y_r;
                        y_nx = x_r;
                        z_nx = -HALF_PI_FL;
                    end
                end
            end
            ST_ITER: begin
                d_pos = (mode == MODE_ROT) ? !z_r[IW-1] : y_r[IW-1];
                if (d_pos) begin
                    x_nx = x_r - ys;
                    y_nx = y_r + xs;
                    z_nx = z_r - atan_i;
                end else begin
                    x_nx = x_r + ys;
                    y_nx = y_r - xs;
                    z_nx = z_r + atan_i;
                end
            end
            ST_SCALE: begin
                x_nx = round_prod(px);
                y_nx = round_prod(py);
            end
            default: ;
        endcase
    end

    cordic_sat #(.IW(IW), .OW(WL)) u_sat_x (.din(x_nx), .dout(sx), .clip(cx));
    cordic_sat #(.IW(IW), .OW(WL)) u_sat_y (.din(y_nx), .dout(sy), .clip(cy));
    cordic_sat #(.IW(IW), .OW(WL)) u_sat_z (.din(z_nx), .dout(sz), .clip(cz));

    // Accumulators carry no reset: they are always loaded at capture.
    always_ff @(posedge clk) begin
        x_r <= x_nx;
        y_r <= y_nx;
        z_r <= z_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode      <= MODE_ROT;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        mode     <= in_mode;
                        in_ready <= 1'b0;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    cnt   <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (last_iter) begin
                        cnt   <= '0;
                        state <= (COMP_GAIN != 0) ? ST_SCALE : ST_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SCALE: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (load_out) begin
                out_x     <= sx;
                out_y     <= sy;
                out_z     <= sz;
                out_sat   <= cx | cy | cz;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_multimode.sv
// Scoreboard bench for cordic_multimode: stimulus pushes hand-computed
// expectations, per-DUT monitors pop and compare on each output handshake.
module tb_cordic_multimode;
    import cordic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0, in_valid1 = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
    logic signed [15:0] in_x = '0, in_y = '0, in_z = '0;
    logic               in_ready, out_valid, out_sat;
    logic signed [15:0] out_x, out_y, out_z;
    logic               in_ready1, out_valid1, out_sat1;
    logic signed [15:0] out_x1, out_y1, out_z1;

    cordic_multimode #(.WL(16), .FL(13), .N_ITER(15), .GUARD(2), .COMP_GAIN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_sat(out_sat));

    cordic_multimode #(.WL(16), .FL(13), .N_ITER(15), .GUARD(2), .COMP_GAIN(0)) u_raw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_x(out_x1), .out_y(out_y1), .out_z(out_z1), .out_sat(out_sat1));

    typedef struct {
        string name;
        int    ex, ey, ez;
        int    tx, ty, tz;
        bit    esat;
        int    lat;
        int    cap;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     n_chk = 0;
    int     n_pass = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t mk(input string n, input int ex, input int ey, input int ez,
                                input int tx, input int ty, input int tz, input bit esat,
                                input int lat);
        exp_t e;
        e.name = n; e.ex = ex; e.ey = ey; e.ez = ez;
        e.tx = tx; e.ty = ty; e.tz = tz; e.esat = esat; e.lat = lat; e.cap = 0;
        return e;
    endfunction

    task automatic chk(input string name, input bit ok, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic check_result(input exp_t e, input int ox, input int oy, input int oz,
                                input bit os, input int lat);
        chk($sformatf("%s.x", e.name), iabs(ox - e.ex) <= e.tx,
            $sformatf("got %0d want %0d +/-%0d", ox, e.ex, e.tx));
        chk($sformatf("%s.y", e.name), iabs(oy - e.ey) <= e.ty,
            $sformatf("got %0d want %0d +/-%0d", oy, e.ey, e.ty));
        chk($sformatf("%s.z", e.name), iabs(oz - e.ez) <= e.tz,
            $sformatf("got %0d want %0d +/-%0d", oz, e.ez, e.tz));
        chk($sformatf("%s.sat", e.name), os == e.esat,
            $sformatf("got %0d want %0d", os, e.esat));
        chk($sformatf("%s.lat", e.name), lat == e.lat,
            $sformatf("got %0d want %0d", lat, e.lat));
    endtask

    initial begin : mon0
        bit   prev;
        int   rise;
        exp_t e;
        prev = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev) rise = int'(cyc);
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    chk("unexpected_out", 1'b0, $sformatf("got out_x=%0d want no result", out_x));
                end else begin
                    e = q0.pop_front();
                    check_result(e, int'(out_x), int'(out_y), int'(out_z), out_sat, rise - e.cap);
                end
            end
            prev = out_valid;
        end
    end

    initial begin : mon1
        bit   prev;
        int   rise;
        exp_t e;
        prev = 1'b0;
        rise = 0;
        forever begin
            @(negedge clk);
            if (out_valid1 && !prev) rise = int'(cyc);
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    chk("unexpected_out_raw", 1'b0, $sformatf("got out_x=%0d want no result", out_x1));
                end else begin
                    e = q1.pop_front();
                    check_result(e, int'(out_x1), int'(out_y1), int'(out_z1), out_sat1, rise - e.cap);
                end
            end
            prev = out_valid1;
        end
    end

    task automatic issue(input bit which, input logic mode, input int x, input int y,
                         input int z, input bit push, input exp_t e);
        int   g;
        exp_t en;
        g = 0;
        while (!(which ? in_ready1 : in_ready) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) chk("ready_timeout", 1'b0, "in_ready=0 want 1 within 200 cycles");
        in_mode = mode;
        in_x = x[15:0];
        in_y = y[15:0];
        in_z = z[15:0];
        if (which) in_valid1 = 1'b1;
        else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        en = e;
        en.cap = int'(cyc);
        if (push) begin
            if (which) q1.push_back(en);
            else q0.push_back(en);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) chk("drain_timeout", 1'b0, $sformatf("pending=%0d want 0", q0.size() + q1.size()));
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic signed [15:0] sx, sy, sz;
        int                 g;
        bit                 seen;
        exp_t               dummy;
        dummy = mk("none", 0, 0, 0, 0, 0, 0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", in_ready == 1'b1 && in_ready1 == 1'b1, $sformatf("got %0d/%0d want 1/1", in_ready, in_ready1));
        chk("reset_valid", out_valid == 1'b0 && out_valid1 == 1'b0, $sformatf("got %0d/%0d want 0/0", out_valid, out_valid1));
        chk("reset_data", out_x == 0 && out_y == 0 && out_z == 0 && out_sat == 1'b0,
            $sformatf("got %0d %0d %0d %0d want 0 0 0 0", out_x, out_y, out_z, out_sat));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // main function, all quadrant pre-rotation branches
        issue(0, MODE_ROT, 8192, 0, 6434, 1, mk("rot45", 5793, 5793, 0, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_VEC, -8192, 8192, 0, 1, mk("vec135", 11585, 0, 19302, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_ROT, 8192, 0, 25736, 1, mk("rot_pi", -8192, 0, 0, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_ROT, 8192, 0, -25736, 1, mk("rot_mpi", -8192, 0, 0, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_ROT, 0, 8192, -6434, 1, mk("rot_m45", 5793, 5793, 0, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_VEC, 8192, -8192, 0, 1, mk("vec_m45", 11585, 0, -6434, 4, 4, 4, 1'b0, 17));
        issue(0, MODE_VEC, -8192, -8192, 0, 1, mk("vec_m135", 11585, 0, -19302, 4, 4, 4, 1'b0, 17));
        drain();

        // backpressure
        out_ready = 1'b0;
        issue(0, MODE_ROT, 8192, 0, 0, 1, mk("bp", 8192, 0, 0, 4, 4, 4, 1'b0, 17));
        g = 0;
        while (!out_valid && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("bp_wait", out_valid == 1'b1, $sformatf("out_valid=%0d want 1 within 40 cycles", out_valid));
        sx = out_x; sy = out_y; sz = out_z;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_x = 16'sd1234; in_y = 16'sd777; in_z = 16'sd6434;
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", i),
                out_valid && !in_ready && out_x == sx && out_y == sy && out_z == sz,
                $sformatf("got v=%0d rdy=%0d x=%0d y=%0d z=%0d want v=1 rdy=0 x=%0d y=%0d z=%0d",
                          out_valid, in_ready, out_x, out_y, out_z, sx, sy, sz));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", in_ready == 1'b1 && out_valid == 1'b0,
            $sformatf("got rdy=%0d v=%0d want rdy=1 v=0", in_ready, out_valid));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_phantom", !seen, $sformatf("out_valid seen=%0d want 0", seen));

        // reset in the middle of the iterations (step 5)
        issue(0, MODE_ROT, 8192, 0, 6434, 0, dummy);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", out_valid == 1'b0 && out_x == 0 && out_y == 0 && out_z == 0 && out_sat == 1'b0,
            $sformatf("got v=%0d x=%0d y=%0d z=%0d s=%0d want all 0", out_valid, out_x, out_y, out_z, out_sat));
        chk("rst_ready", in_ready == 1'b1, $sformatf("got %0d want 1", in_ready));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_abort", !seen, $sformatf("out_valid seen=%0d want 0", seen));
        issue(0, MODE_ROT, 8192, 0, 6434, 1, mk("rot45_after_rst", 5793, 5793, 0, 4, 4, 4, 1'b0, 17));
        drain();

        // raw-gain engine, magnitude clips
        issue(1, MODE_VEC, 32767, 32767, 0, 1, mk("raw_sat", 32767, 0, 6434, 0, 64, 4, 1'b1, 16));
        drain();

        chk("queues_empty", q0.size() == 0 && q1.size() == 0,
            $sformatf("pending=%0d want 0", q0.size() + q1.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
